// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: state encoding, field widths and frame packing.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [ADDR_W-1:0] a,
                                                       input logic              rw,
                                                       input logic [DATA_W-1:0] d);
    return {a, rw, d};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period down-counter: reloads CLK_DIV-1 while disabled or at zero,
// and emits a one-cycle tick when it reaches zero while enabled.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (!en || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = en && (cnt == 8'd0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: one 16-bit {addr, rw, data} frame per accepted start,
// with registered cs/sclk/mosi, read-data capture and an enforced inter-frame gap.
//
// state    | meaning
// IDLE     | cs high, waiting for start
// SETUP    | cs low, first bit on mosi, one half-period before first sclk rise
// SHIFT    | 16 sclk periods; sample miso at end of high half, shift at end of low half
// HOLD     | cs low, sclk low for one half-period after the last bit
// DONE     | single cycle: cs high, done pulse, read data captured
// GAP      | cs high, busy held for CLK_DIV-1 cycles before returning to IDLE
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [4:0] BIT_TC     = 5'(FRAME_BITS);
  localparam logic [7:0] GAP_RELOAD = 8'(CLK_DIV - 2);

  spi_state_e            state, state_nxt;
  logic [FRAME_BITS-1:0] tx, tx_nxt;
  logic [FRAME_BITS-1:0] rx, rx_nxt;
  logic [4:0]            bit_cnt, bit_cnt_nxt;
  logic [7:0]            gap_cnt, gap_cnt_nxt;
  logic                  rw_q, rw_q_nxt;
  logic                  cs_nxt, sclk_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0]     rdata_nxt;
  logic                  tick, tick_en;
  logic                  rx_hi_unused;

  assign tick_en      = (state != ST_IDLE) && (state != ST_GAP);
  assign mosi         = tx[FRAME_BITS-1];
  assign rx_hi_unused = ^rx[FRAME_BITS-1:DATA_W];

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= 5'd0;
      gap_cnt <= 8'd0;
      rw_q    <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      rx      <= rx_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      rw_q    <= rw_q_nxt;
      cs      <= cs_nxt;
      sclk    <= sclk_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx;
    rx_nxt      = rx;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    rw_q_nxt    = rw_q;
    cs_nxt      = cs;
    sclk_nxt    = sclk;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    rdata_nxt   = rdata;

    case (state)
      ST_IDLE: begin
        cs_nxt   = 1'b1;
        sclk_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          tx_nxt      = pack_frame(addr, rw, wdata);
          rx_nxt      = '0;
          rw_q_nxt    = rw;
          bit_cnt_nxt = 5'd0;
          cs_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          sclk_nxt  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (sclk) begin
            rx_nxt      = {rx[FRAME_BITS-2:0], miso};
            bit_cnt_nxt = bit_cnt + 5'd1;
            sclk_nxt    = 1'b0;
          end else if (bit_cnt == BIT_TC) begin
            state_nxt = ST_HOLD;
          end else begin
            tx_nxt   = {tx[FRAME_BITS-2:0], 1'b0};
            sclk_nxt = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          cs_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
          if (rw_q == RW_READ) rdata_nxt = rx[DATA_W-1:0];
        end
      end

      ST_DONE: begin
        gap_cnt_nxt = GAP_RELOAD;
        state_nxt   = ST_GAP;
      end

      ST_GAP: begin
        // busy drops together with the return to IDLE so a held start is taken next cycle
        if (gap_cnt == 8'd0) begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end

      default: begin
        cs_nxt    = 1'b1;
        sclk_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Self-checking bench for spi_txn_ctrl: CLK_DIV=4 instance plus a CLK_DIV=2 instance,
// with a slave model on miso and expectations derived from frame timing arithmetic.
module tb_spi_txn_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0, miso2 = 1'b0;
  logic       busy, done, cs, sclk, mosi;
  logic [7:0] rdata;
  logic       busy2, done2, cs2, sclk2, mosi2;
  logic [7:0] rdata2;

  int total = 0;
  int bad = 0;

  // monitor state, updated once per cycle by step()
  int          cyc, rises, falls, done_cnt, done_cyc, cs_tog;
  logic [15:0] mosi_cap, slave_word;
  logic [7:0]  done_rdata, model_rdata;
  logic        sclk_prev;
  int          rises2, r2a, r2b, done2_cyc, done2_cnt;
  logic [15:0] mosi2_cap;
  logic        sclk2_prev;

  spi_txn_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_txn_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .addr(addr), .rw(rw), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .cs(cs2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sclk && !sclk_prev) begin
      if (rises < 16) mosi_cap[15-rises] = mosi;
      rises++;
    end
    if (cs && (sclk != sclk_prev)) cs_tog++;
    if (!sclk && sclk_prev && !cs) falls++;
    if (cs) falls = 0;
    miso = (falls < 16) ? slave_word[15-falls] : 1'b0;
    if (done) begin done_cnt++; done_cyc = cyc; done_rdata = rdata; end
    sclk_prev = sclk;
    if (sclk2 && !sclk2_prev) begin
      if (rises2 < 16) mosi2_cap[15-rises2] = mosi2;
      rises2++;
      if (rises2 == 1) r2a = cyc;
      if (rises2 == 2) r2b = cyc;
    end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    sclk2_prev = sclk2;
  endtask

  task automatic clear_monitor();
    cyc = 0; rises = 0; falls = 0; done_cnt = 0; done_cyc = -1; cs_tog = 0;
    mosi_cap = '0; done_rdata = '0;
    rises2 = 0; r2a = -1; r2b = -1; done2_cyc = -1; done2_cnt = 0; mosi2_cap = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    model_rdata = 8'h00;
    step();
    total++;
    if ({cs, sclk, mosi, busy, done} !== 5'b10000) begin
      bad++; $display("FAIL reset_outputs: got cs,sclk,mosi,busy,done=%b want 10000", {cs, sclk, mosi, busy, done});
    end
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
  endtask

  // one CLK_DIV=4 frame; expected timing: done at 1+34*4, busy low at 1+35*4
  task automatic run_frame(input logic [6:0] a, input logic r, input logic [7:0] d, input logic [15:0] sw);
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
    int          first_rise, busy_end;
    exp_frame  = {a, r, d};
    exp_rdata  = r ? sw[7:0] : model_rdata;
    first_rise = -1;
    busy_end   = -1;
    clear_monitor();
    slave_word = sw;
    miso = sw[15];
    addr = a; rw = r; wdata = d; start = 1'b1;
    step();
    start = 1'b0;
    addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    total++;
    if ({cs, busy, mosi} !== {1'b0, 1'b1, exp_frame[15]}) begin
      bad++; $display("FAIL frame_cycle1: got cs,busy,mosi=%b want %b", {cs, busy, mosi}, {2'b01, exp_frame[15]});
    end
    while (busy_end < 0 && cyc < 400) begin
      step();
      if (first_rise < 0 && rises > 0) first_rise = cyc;
      if (!busy) busy_end = cyc;
    end
    total++;
    if (first_rise !== 5) begin bad++; $display("FAIL first_rise: got %0d want 5", first_rise); end
    total++;
    if (rises !== 16) begin bad++; $display("FAIL sclk_rises: got %0d want 16", rises); end
    total++;
    if (mosi_cap !== exp_frame) begin bad++; $display("FAIL mosi_bits: got %b want %b", mosi_cap, exp_frame); end
    total++;
    if (done_cnt !== 1 || done_cyc !== 137) begin
      bad++; $display("FAIL done_timing: got count=%0d cycle=%0d want 1 at 137", done_cnt, done_cyc);
    end
    total++;
    if (done_rdata !== exp_rdata || rdata !== exp_rdata) begin
      bad++; $display("FAIL rdata: got at_done=%h after=%h want %h", done_rdata, rdata, exp_rdata);
    end
    total++;
    if (busy_end !== 141) begin bad++; $display("FAIL busy_end: got %0d want 141", busy_end); end
    total++;
    if (cs_tog !== 0) begin bad++; $display("FAIL sclk_while_cs_high: got %0d toggles want 0", cs_tog); end
    model_rdata = exp_rdata;
  endtask

  task automatic test_write();
    run_frame(7'h15, 1'b0, 8'hA5, 16'hFFFF);
    for (int i = 0; i < 3; i++) run_frame(7'($urandom), 1'b0, 8'($urandom), 16'($urandom));
  endtask

  task automatic test_read();
    run_frame(7'h7F, 1'b1, 8'($urandom), {8'($urandom), 8'h3C});
    for (int i = 0; i < 3; i++) run_frame(7'($urandom), 1'b1, 8'($urandom), 16'($urandom));
    run_frame(7'($urandom), 1'b0, 8'($urandom), 16'($urandom));
  endtask

  task automatic test_abort();
    clear_monitor();
    slave_word = 16'hBEEF;
    miso = slave_word[15];
    addr = 7'h2A; rw = 1'b1; wdata = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 40) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_rdata = 8'h00;
    total++;
    if ({cs, sclk, busy, done} !== 4'b1000) begin
      bad++; $display("FAIL abort_outputs: got cs,sclk,busy,done=%b want 1000", {cs, sclk, busy, done});
    end
    repeat (200) step();
    total++;
    if (done_cnt !== 0 || rdata !== model_rdata) begin
      bad++; $display("FAIL abort_no_done: got dones=%0d rdata=%h want 0 and %h", done_cnt, rdata, model_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int cs_high;
    clear_monitor();
    cs_high = 0;
    slave_word = 16'($urandom);
    addr = 7'h11; rw = 1'b0; wdata = 8'h5A; start = 1'b1;
    while (cyc < 142) begin
      step();
      if (cyc >= 137 && cyc <= 141 && cs) cs_high++;
      if (cyc == 60) addr = 7'h22;
    end
    total++;
    if (cs_high !== 5) begin bad++; $display("FAIL gap_cs_high: got %0d cycles want 5", cs_high); end
    total++;
    if ({cs, busy} !== 2'b01) begin bad++; $display("FAIL second_accept: got cs,busy=%b want 01", {cs, busy}); end
    while (cyc < 300) begin
      step();
      if (cyc == 150) start = 1'b0;
    end
    total++;
    if (done_cnt !== 2 || done_cyc !== 278) begin
      bad++; $display("FAIL back_to_back_done: got count=%0d last=%0d want 2 at 278", done_cnt, done_cyc);
    end
    step();
  endtask

  task automatic test_clkdiv2();
    logic [15:0] exp_frame;
    exp_frame = {7'($urandom), 1'b0, 8'($urandom)};
    clear_monitor();
    {addr, rw, wdata} = exp_frame;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    while (done2_cnt == 0 && cyc < 200) step();
    total++;
    if (done2_cyc !== 69) begin bad++; $display("FAIL div2_done: got %0d want 69", done2_cyc); end
    total++;
    if (r2a !== 3 || r2b - r2a !== 4) begin
      bad++; $display("FAIL div2_sclk: got first=%0d period=%0d want 3 and 4", r2a, r2b - r2a);
    end
    total++;
    if (rises2 !== 16 || mosi2_cap !== exp_frame) begin
      bad++; $display("FAIL div2_frame: got rises=%0d bits=%b want 16 and %b", rises2, mosi2_cap, exp_frame);
    end
    repeat (10) step();
  endtask

  task automatic test_reset_start();
    reset = 1'b1; start = 1'b1;
    step();
    total++;
    if ({cs, busy} !== 2'b10) begin bad++; $display("FAIL reset_start: got cs,busy=%b want 10", {cs, busy}); end
    reset = 1'b0; start = 1'b0;
    repeat (3) step();
    model_rdata = 8'h00;
    total++;
    if ({cs, busy, sclk, rdata} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL reset_start_idle: got cs,busy,sclk=%b rdata=%h want 100 00", {cs, busy, sclk}, rdata);
    end
  endtask

  initial begin
    sclk_prev = 1'b0; sclk2_prev = 1'b0; slave_word = '0; model_rdata = '0;
    clear_monitor();
    test_reset();
    test_abort();
    test_write();
    test_read();
    test_back_to_back();
    test_clkdiv2();
    test_reset_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_txn_ctrl.md
SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, is the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  in  1  single system clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request one frame; sampled only in IDLE.
REQ-005 addr  in  7  target address; captured when start is accepted.
REQ-006 rw  in  1  1 = read, 0 = write; captured when start is accepted.
REQ-007 wdata  in  8  write data; captured when start is accepted.
REQ-008 busy  out  1  high from the cycle after start is accepted until the GAP state ends.
REQ-009 done  out  1  one-cycle pulse marking the end of a frame.
REQ-010 rdata  out  8  read result; valid from the done pulse and held until the next read's done.
REQ-011 cs  out  1  chip select, active low, idle high.
REQ-012 sclk  out  1  serial clock, idle low.
REQ-013 mosi  out  1  serial data to the downstream FSM and shift register.
REQ-014 miso  in  1  serial data from the slave.

Function
REQ-015 Frame format: 16 bits, MSB first, ordered {addr[6:0], rw, wdata[7:0]}; for a read, the data bits on mosi are don't-care.
REQ-016 States: IDLE, SETUP, SHIFT, HOLD, DONE, GAP; all outputs registered.
REQ-017 IDLE: cs=1, sclk=0, busy=0; start=1 latches addr, rw and wdata into a 16-bit tx register and moves to SETUP. Call this accept cycle 0.
REQ-018 SETUP: cs=0 and mosi=tx[15] from cycle 1; lasts CLK_DIV cycles, then moves to SHIFT.
REQ-019 SHIFT: 16 bit periods, each CLK_DIV cycles with sclk=1 followed by CLK_DIV cycles with sclk=0; first sclk rise is at cycle 1+CLK_DIV.
REQ-020 miso is sampled into a 16-bit rx register on the clk edge that ends each sclk-high half-period.
REQ-021 The tx register shifts left, and mosi updates, on the clk edge that ends each sclk-low half-period; there is no shift after bit 16.
REQ-022 HOLD: cs=0, sclk=0 for CLK_DIV cycles after the 16th falling edge.
REQ-023 DONE: one cycle at 1+34*CLK_DIV with cs=1, done=1, busy=1. If the captured rw=1, rdata loads rx[7:0] (bits 9..16); if rw=0, rdata is unchanged.
REQ-024 GAP: cs=1, busy=1 for CLK_DIV-1 cycles after DONE, then IDLE. Between back-to-back frames, cs stays high for at least CLK_DIV+1 cycles, so the slave sees a clean cs posedge/negedge.
REQ-025 start while busy=1 is ignored, not queued; addr, rw and wdata may change freely after acceptance.
REQ-026 Exactly 16 sclk rising edges occur per frame; sclk never toggles while cs=1.
REQ-027 Bit counter: 5 bits, terminal count 16. Half-period counter: 8 bits, reloads CLK_DIV-1 and counts down to 0, with no wrap-around artefacts.

Reset
REQ-028 On reset: state=IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, tx=0, rx=0, counters=0.
REQ-029 Reset mid-frame aborts the frame on the next clk edge: cs=1, sclk=0, no done pulse.
REQ-030 Reset wins over start asserted in the same cycle.

Structure
REQ-031 Package spi_pkg holds the state encoding, FRAME_BITS=16, ADDR_W=7, DATA_W=8 and RW_READ=1'b1, shared with the downstream master and slave FSMs.
REQ-032 One sub-module, spi_tick_gen, is the half-period down-counter emitting a one-cycle tick; it is enabled outside IDLE and GAP.

Verification
REQ-033 CLK_DIV=4, write addr=0x15, rw=0, wdata=0xA5 -> mosi at the 16 rises = 0010101_0_10100101; done at cycle 137; rdata unchanged.
REQ-034 CLK_DIV=4, read addr=0x7F, rw=1, slave model drives 0x3C on bits 9-16 -> rdata=0x3C at done (cycle 137); exactly 16 sclk rises.
REQ-035 start held high continuously -> frames accepted at cycles 0 and 141; cs high for cycles 137-141 inclusive; extra starts ignored.
REQ-036 Reset at cycle 40 of a read -> cycle 41: cs=1, sclk=0, busy=0; no done pulse; rdata keeps its previous value.
REQ-037 CLK_DIV=2 write -> sclk period 4 clk cycles; done at cycle 69.
REQ-038 reset and start asserted in the same cycle -> IDLE persists with cs=1 and busy=0 the following cycle.
